// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: forwarding, load-use stall, redirect flush and data-memory wait control for the 5-stage pipe.
// Optional HAZ_PERF_EN builds saturating stall/flush/wait performance counters.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT  = 15,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  id_rs_i,
  input  logic [4:0]  id_rt_i,
  input  logic        id_use_rs_i,
  input  logic        id_use_rt_i,
  input  logic [4:0]  exe_d_i,
  input  logic        exe_wreg_i,
  input  logic        exe_m2reg_i,
  input  logic [4:0]  mem_d_i,
  input  logic        mem_wreg_i,
  input  logic        mem_m2reg_i,
  input  logic [1:0]  pcsource_i,
  input  logic        mem_req_i,
  input  logic        mem_ack_i,
  output logic [1:0]  fwda_o,
  output logic [1:0]  fwdb_o,
  output logic        wpcir_o,
  output logic        id_bubble_o,
  output logic        if_flush_o,
  output logic        pipe_hold_o,
  output logic        mem_err_o,
  output logic [1:0]  state_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o,
  output logic [31:0] wait_cnt_o
);
  typedef enum logic [1:0] {RUN = 2'b00, MWAIT = 2'b01, FLUSH = 2'b10} state_t;
  localparam logic [7:0] TO = 8'(MEM_TIMEOUT);
  localparam logic [2:0] FC = 3'(FLUSH_CYCLES);
  state_t state_q, state_d;
  logic [7:0] wcnt_q, wcnt_d;
  logic [2:0] fcnt_q, fcnt_d;
  logic err_q, err_d;
  logic lu, mwait, redirect;
  always_comb begin
    fwda_o = (id_use_rs_i && exe_wreg_i && exe_d_i == id_rs_i && exe_d_i != 5'd0) ? 2'b01 :
             (mem_wreg_i && mem_d_i == id_rs_i && mem_d_i != 5'd0) ? {1'b1, mem_m2reg_i} : 2'b00;
    fwdb_o = (id_use_rt_i && exe_wreg_i && exe_d_i == id_rt_i && exe_d_i != 5'd0) ? 2'b01 :
             (mem_wreg_i && mem_d_i == id_rt_i && mem_d_i != 5'd0) ? {1'b1, mem_m2reg_i} : 2'b00;
  end
  assign lu = exe_wreg_i && exe_m2reg_i && exe_d_i != 5'd0 &&
              ((id_use_rs_i && exe_d_i == id_rs_i) || (id_use_rt_i && exe_d_i == id_rt_i));
  assign mwait = mem_req_i && !mem_ack_i;
  assign redirect = pcsource_i != 2'b00;
  assign state_o = state_q;
  assign mem_err_o = err_q;
  // fcnt_q holds the flush cycles still owed, so it survives an MWAIT detour
  always_comb begin
    state_d = state_q;
    wcnt_d = wcnt_q;
    fcnt_d = fcnt_q;
    err_d = err_q;
    wpcir_o = 1'b1;
    id_bubble_o = 1'b0;
    if_flush_o = 1'b0;
    pipe_hold_o = 1'b0;
    if (state_q == MWAIT) begin
      pipe_hold_o = 1'b1;
      wpcir_o = 1'b0;
      if (mem_ack_i || wcnt_q == TO) begin
        state_d = fcnt_q != 3'd0 ? FLUSH : RUN;
        err_d = err_q | ~mem_ack_i;
      end else
        wcnt_d = wcnt_q + 8'd1;
    end else if (mwait) begin
      pipe_hold_o = 1'b1;
      wpcir_o = 1'b0;
      state_d = MWAIT;
      wcnt_d = 8'd1;
    end else if (state_q == FLUSH) begin
      if_flush_o = 1'b1;
      fcnt_d = redirect ? FC : fcnt_q - 3'd1;
      state_d = (!redirect && fcnt_q == 3'd1) ? RUN : FLUSH;
    end else if (lu) begin
      wpcir_o = 1'b0;
      id_bubble_o = 1'b1;
    end else if (redirect) begin
      if_flush_o = 1'b1;
      if (FLUSH_CYCLES > 0) begin
        state_d = FLUSH;
        fcnt_d = FC;
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
      wcnt_q <= 8'd0;
      fcnt_q <= 3'd0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q <= wcnt_d;
      fcnt_q <= fcnt_d;
      err_q <= err_d;
    end
  end
`ifdef HAZ_PERF_EN
  logic [31:0] sc_q, fc_q, wc_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sc_q <= 32'd0;
      fc_q <= 32'd0;
      wc_q <= 32'd0;
    end else begin
      if (id_bubble_o && sc_q != '1) sc_q <= sc_q + 32'd1;
      if (if_flush_o && fc_q != '1) fc_q <= fc_q + 32'd1;
      if (pipe_hold_o && wc_q != '1) wc_q <= wc_q + 32'd1;
    end
  end
  assign stall_cnt_o = sc_q;
  assign flush_cnt_o = fc_q;
  assign wait_cnt_o = wc_q;
`else
  assign stall_cnt_o = 32'd0;
  assign flush_cnt_o = 32'd0;
  assign wait_cnt_o = 32'd0;
`endif
endmodule
